object_bound_scheduler: RTL

//   Owns the N fruit/bomb object slots and shares one registered out-of-bound checker among them.

---
 rtl/object_bound_scheduler_if.sv | 49 ++++
 rtl/object_bound_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/object_bound_scheduler_if.sv
// Bundle between the object slot scheduler and its neighbours:
// motion data, checker operands, spawn/slice/retire events.
interface object_bound_scheduler_if #(
  parameter int N_OBJ  = 8,
  parameter int IDX_W  = 3,
  parameter int MISS_W = 8
);
  logic                frame_tick;
  logic [N_OBJ*10-1:0] obj_posx;
  logic [N_OBJ*9-1:0]  obj_posy;
  logic [N_OBJ*10-1:0] obj_width;
  logic [N_OBJ*9-1:0]  obj_height;
  logic [9:0]          chk_posx;
  logic [8:0]          chk_posy;
  logic [9:0]          chk_width;
  logic [8:0]          chk_height;
  logic                chk_flag;
  logic                spawn_req;
  logic                spawn_ack;
  logic                spawn_nack;
  logic [IDX_W-1:0]    spawn_slot;
  logic                slice_valid;
  logic [IDX_W-1:0]    slice_slot;
  logic [N_OBJ-1:0]    active_mask;
  logic                retire_valid;
  logic [IDX_W-1:0]    retire_slot;
  logic [MISS_W-1:0]   missed_count;
  logic                scan_busy;

  modport master (
    input  frame_tick, obj_posx, obj_posy,
    input  obj_width, obj_height, chk_flag,
    input  spawn_req, slice_valid, slice_slot,
    output chk_posx, chk_posy, chk_width, chk_height,
    output spawn_ack, spawn_nack, spawn_slot,
    output active_mask, retire_valid, retire_slot,
    output missed_count, scan_busy
  );

  modport slave (
    output frame_tick, obj_posx, obj_posy,
    output obj_width, obj_height, chk_flag,
    output spawn_req, slice_valid, slice_slot,
    input  chk_posx, chk_posy, chk_width, chk_height,
    input  spawn_ack, spawn_nack, spawn_slot,
    input  active_mask, retire_valid, retire_slot,
    input  missed_count, scan_busy
  );
endinterface

// File: rtl/object_bound_scheduler.sv
// Object slot owner: per-frame bound scan through one shared
// checker, spawn allocation, slice frees and miss counting.
module object_bound_scheduler #(
  parameter int N_OBJ  = 8,
  parameter int IDX_W  = 3,
  parameter int MISS_W = 8
) (
  input logic clk,
  input logic rst,
  object_bound_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_OBJ - 1);

  state_t            state;
  state_t            state_n;
  logic [IDX_W-1:0]  scan_idx;
  logic              iss_vld;
  logic [IDX_W-1:0]  iss_idx;
  logic              iss_act;
  logic [N_OBJ-1:0]  active;
  logic [N_OBJ-1:0]  armed;
  logic [N_OBJ-1:0]  active_n;
  logic [N_OBJ-1:0]  armed_n;
  logic [9:0]        chk_posx;
  logic [8:0]        chk_posy;
  logic [9:0]        chk_width;
  logic [8:0]        chk_height;
  logic              spawn_ack;
  logic              spawn_nack;
  logic [IDX_W-1:0]  spawn_slot;
  logic              retire_valid;
  logic [IDX_W-1:0]  retire_slot;
  logic [MISS_W-1:0] missed;
  logic              free_hit;
  logic [IDX_W-1:0]  free_idx;
  logic              commit_go;
  logic              slice_go;
  logic              slice_hit;
  logic              retire_go;
  logic              arm_go;
  logic              grant_go;

  // Scan sequencer next state
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.frame_tick) state_n = SCAN;
      SCAN:    if (scan_idx == LAST) state_n = DRAIN;
      DRAIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Scan sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Issue stage: present slot operands, remember slot for commit
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx   <= '0;
      iss_vld    <= 1'b0;
      iss_idx    <= '0;
      iss_act    <= 1'b0;
      chk_posx   <= '0;
      chk_posy   <= '0;
      chk_width  <= '0;
      chk_height <= '0;
    end else begin
      iss_vld <= (state == SCAN);
      if (state == SCAN) begin
        chk_posx   <= bus.obj_posx[scan_idx*10 +: 10];
        chk_posy   <= bus.obj_posy[scan_idx*9 +: 9];
        chk_width  <= bus.obj_width[scan_idx*10 +: 10];
        chk_height <= bus.obj_height[scan_idx*9 +: 9];
        iss_idx    <= scan_idx;
        iss_act    <= active[scan_idx];
        scan_idx   <= (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
      end
    end
  end

  // Lowest-index free slot for spawn grants
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Commit decode; a same-cycle slice beats arm and retire
  always_comb begin
    commit_go = iss_vld & iss_act & active[iss_idx];
    slice_go  = bus.slice_valid & active[bus.slice_slot];
    slice_hit = slice_go & (bus.slice_slot == iss_idx);
    retire_go = commit_go & bus.chk_flag
              & armed[iss_idx] & ~slice_hit;
    arm_go    = commit_go & ~bus.chk_flag & ~slice_hit;
    grant_go  = bus.spawn_req & free_hit;
  end

  // Slot table next values
  always_comb begin
    active_n = active;
    armed_n  = armed;
    if (arm_go) armed_n[iss_idx] = 1'b1;
    if (retire_go) begin
      active_n[iss_idx] = 1'b0;
      armed_n[iss_idx]  = 1'b0;
    end
    if (slice_go) begin
      active_n[bus.slice_slot] = 1'b0;
      armed_n[bus.slice_slot]  = 1'b0;
    end
    if (grant_go) begin
      active_n[free_idx] = 1'b1;
      armed_n[free_idx]  = 1'b0;
    end
  end

  // Slot table, event pulses and miss counter
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= '0;
      armed        <= '0;
      spawn_ack    <= 1'b0;
      spawn_nack   <= 1'b0;
      spawn_slot   <= '0;
      retire_valid <= 1'b0;
      retire_slot  <= '0;
      missed       <= '0;
    end else begin
      active       <= active_n;
      armed        <= armed_n;
      spawn_ack    <= grant_go;
      spawn_nack   <= bus.spawn_req & ~free_hit;
      spawn_slot   <= grant_go ? free_idx : '0;
      retire_valid <= retire_go;
      retire_slot  <= retire_go ? iss_idx : '0;
      if (retire_go && !(&missed)) missed <= missed + 1'b1;
    end
  end

  assign bus.chk_posx     = chk_posx;
  assign bus.chk_posy     = chk_posy;
  assign bus.chk_width    = chk_width;
  assign bus.chk_height   = chk_height;
  assign bus.spawn_ack    = spawn_ack;
  assign bus.spawn_nack   = spawn_nack;
  assign bus.spawn_slot   = spawn_slot;
  assign bus.active_mask  = active;
  assign bus.retire_valid = retire_valid;
  assign bus.retire_slot  = retire_slot;
  assign bus.missed_count = missed;
  assign bus.scan_busy    = (state != IDLE);

endmodule
